// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus: valid/ready request channel plus in-order, no-backpressure response.
// The fetch unit is the master; instruction memory is the slave.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches, buffers responses in a
// small FIFO for decode and flushes on redirect. Optional macro IFU_ALIGN_CHECK_EN adds fault marking.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    instr_fetch_unit_if.master   imem,
    input  logic                 redirect_i,
    input  logic [XLEN-1:0]      redirect_pc_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [XLEN-1:0]      instr_o,
    output logic [XLEN-1:0]      instr_pc_o,
    output logic [6:0]           instr_opcode_o,
    output logic                 instr_fault_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] tag_q       [FIFO_DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] tag_rd_q, tag_rd_d;
    logic [PtrW-1:0] tag_wr_q, tag_wr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic [XLEN-1:0] redirect_pc;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_data;
    logic [XLEN-1:0] push_pc;

`ifdef IFU_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] NopInstr = XLEN'(32'h0000_0013);

    logic            fifo_fault_q [FIFO_DEPTH];
    logic            halt_q, halt_d;
    logic            fault_pend_q, fault_pend_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic            misaligned;
    logic            fault_push;
`else
    logic            unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

    // Request side: credit is computed from registered counts only.
    always_comb begin
`ifdef IFU_ALIGN_CHECK_EN
        redirect_pc = redirect_pc_i;
        misaligned  = redirect_pc_i[1:0] != 2'b00;
`else
        redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
        credit_ok      = ({1'b0, outst_q} + {1'b0, count_q}) < (CntW + 1)'(FIFO_DEPTH);
        imem.req_valid = rst_n_i && !redirect_i && credit_ok;
`ifdef IFU_ALIGN_CHECK_EN
        imem.req_valid = imem.req_valid && !halt_q;
`endif
        imem.req_addr  = pc_q;
        req_fire       = imem.req_valid && imem.req_ready;
    end

    // Response and FIFO control.
    always_comb begin
        instr_valid_o = count_q != '0;
        pop           = instr_valid_o && instr_ready_i && !redirect_i;
        rsp_take      = rst_n_i && imem.rsp_valid && (drop_q == '0) && !redirect_i;
`ifdef IFU_ALIGN_CHECK_EN
        // The fault marker waits until every stale response has been discarded.
        fault_push = rst_n_i && fault_pend_q && (drop_q == '0) && !redirect_i && !rsp_take;
        push       = rsp_take || fault_push;
        push_data  = fault_push ? NopInstr : imem.rsp_data;
        push_pc    = fault_push ? fault_pc_q : tag_q[tag_rd_q];
`else
        push       = rsp_take;
        push_data  = imem.rsp_data;
        push_pc    = tag_q[tag_rd_q];
`endif
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;
        count_d  = count_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
`ifdef IFU_ALIGN_CHECK_EN
        halt_d       = halt_q;
        fault_pend_d = fault_pend_q;
        fault_pc_d   = fault_pc_q;
`endif
        if (redirect_i) begin
            // Everything in flight becomes stale; a response landing this cycle is one of them.
            pc_d     = redirect_pc;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            outst_d  = '0;
            drop_d   = drop_q + outst_q - CntW'(imem.rsp_valid);
            tag_rd_d = tag_wr_q;
`ifdef IFU_ALIGN_CHECK_EN
            halt_d       = misaligned;
            fault_pend_d = misaligned;
            fault_pc_d   = redirect_pc_i;
`endif
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + XLEN'(4);
                tag_wr_d = tag_wr_q + 1'b1;
            end
            if (imem.rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (rsp_take) begin
                tag_rd_d = tag_rd_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            outst_d = outst_q + CntW'(req_fire) - CntW'(rsp_take);
            count_d = count_q + CntW'(push) - CntW'(pop);
`ifdef IFU_ALIGN_CHECK_EN
            if (fault_push) begin
                fault_pend_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            halt_q       <= 1'b0;
            fault_pend_q <= 1'b0;
            fault_pc_q   <= '0;
`endif
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
`ifdef IFU_ALIGN_CHECK_EN
            halt_q       <= halt_d;
            fault_pend_q <= fault_pend_d;
            fault_pc_q   <= fault_pc_d;
`endif
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_pc_q[wr_ptr_q]   <= push_pc;
`ifdef IFU_ALIGN_CHECK_EN
            fifo_fault_q[wr_ptr_q] <= fault_push;
`endif
        end
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    always_comb begin
        instr_o       = '0;
        instr_pc_o    = '0;
        instr_fault_o = 1'b0;
        if (instr_valid_o) begin
            instr_o    = fifo_data_q[rd_ptr_q];
            instr_pc_o = fifo_pc_q[rd_ptr_q];
`ifdef IFU_ALIGN_CHECK_EN
            instr_fault_o = fifo_fault_q[rd_ptr_q];
`endif
        end
        instr_opcode_o = instr_o[6:0];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1- or 2-cycle instruction memory model.
// Expectations for the optional IFU_ALIGN_CHECK_EN build are selected with the same macro.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  instr_opcode;
    logic        instr_fault;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mem_lat = 1;

    instr_fetch_unit_if #(.XLEN(32)) imem_bus ();

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .imem           (imem_bus),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_opcode_o (instr_opcode),
        .instr_fault_o  (instr_fault)
    );

    always #5 clk = ~clk;

    // Memory image: each word is derived from its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], a[7:0] ^ 8'h5B};
    endfunction

    logic        p1_v = 1'b0;
    logic        p2_v = 1'b0;
    logic [31:0] p1_a = '0;
    logic [31:0] p2_a = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            p1_v <= imem_bus.req_valid && imem_bus.req_ready;
            p2_v <= p1_v;
        end
        p1_a <= imem_bus.req_addr;
        p2_a <= p1_a;
    end

    assign imem_bus.rsp_valid = (mem_lat == 2) ? p2_v : p1_v;
    assign imem_bus.rsp_data  = mem_word((mem_lat == 2) ? p2_a : p1_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int unsigned lat);
        rst_n    = 1'b0;
        redirect = 1'b0;
        mem_lat  = lat;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Waits (bounded) for the next delivered instruction and checks it; assumes instr_ready=1.
    task automatic wait_pop(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr, input logic exp_fault);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (instr_valid && instr_ready) begin
                chk({tag, " pc"}, instr_pc, exp_pc);
                chk({tag, " instr"}, instr, exp_instr);
                chk({tag, " opcode"}, {25'd0, instr_opcode}, {25'd0, exp_instr[6:0]});
                chk({tag, " fault"}, {31'd0, instr_fault}, {31'd0, exp_fault});
                seen = 1'b1;
            end
            tick();
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s: observed no instr_valid within 20 cycles, expected pc %h", tag, exp_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n_hs;
        logic [31:0] exp_req;
        logic [31:0] exp_pop;

        imem_bus.req_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst req_valid", {31'd0, imem_bus.req_valid}, 32'd0);
        chk("rst req_addr", imem_bus.req_addr, 32'h0);
        chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst instr_fault", {31'd0, instr_fault}, 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst opcode", {25'd0, instr_opcode}, 32'd0);

        // Streaming with 1-cycle memory
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            chk("stream req_valid", {31'd0, imem_bus.req_valid}, 32'd1);
            chk("stream req_addr", imem_bus.req_addr, 32'(4 * k));
            if (k >= 2) begin
                chk("stream instr_valid", {31'd0, instr_valid}, 32'd1);
                chk("stream instr_pc", instr_pc, 32'(4 * (k - 2)));
                chk("stream instr", instr, mem_word(32'(4 * (k - 2))));
            end
            tick();
        end

        // Decode stalled: credit limits fetches to FIFO_DEPTH
        instr_ready = 1'b0;
        do_reset(1);
        n_hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_bus.req_valid && imem_bus.req_ready) n_hs++;
            tick();
        end
        chk("stall req count", n_hs, 32'd4);
        chk("stall req_valid", {31'd0, imem_bus.req_valid}, 32'd0);
        chk("stall req_addr", imem_bus.req_addr, 32'h10);
        chk("stall head valid", {31'd0, instr_valid}, 32'd1);
        chk("stall head pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            wait_pop("drain", 32'(4 * i), mem_word(32'(4 * i)), 1'b0);
        end

        // Random request backpressure
        do_reset(1);
        exp_req = 32'h0;
        exp_pop = 32'h0;
        for (int i = 0; i < 60; i++) begin
            imem_bus.req_ready = 1'($urandom_range(0, 1));
            #1;
            if (imem_bus.req_valid && imem_bus.req_ready) begin
                chk("rand req_addr", imem_bus.req_addr, exp_req);
                exp_req += 32'd4;
            end
            if (instr_valid) begin
                chk("rand pop pc", instr_pc, exp_pop);
                chk("rand pop instr", instr, mem_word(exp_pop));
                exp_pop += 32'd4;
            end
            tick();
        end
        chk("rand progress", {31'd0, exp_pop >= 32'h20}, 32'd1);
        imem_bus.req_ready = 1'b1;

        // Redirect with 2 outstanding and 2 buffered (2-cycle memory)
        instr_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 4; i++) tick();
        chk("rd1 pre valid", {31'd0, instr_valid}, 32'd1);
        chk("rd1 pre head", instr_pc, 32'h0);
        chk("rd1 pre credit", {31'd0, imem_bus.req_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rd1 no req", {31'd0, imem_bus.req_valid}, 32'd0);
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("rd1 flushed", {31'd0, instr_valid}, 32'd0);
        chk("rd1 req_valid", {31'd0, imem_bus.req_valid}, 32'd1);
        chk("rd1 req_addr", imem_bus.req_addr, 32'h100);
        wait_pop("rd1 first", 32'h100, mem_word(32'h100), 1'b0);
        wait_pop("rd1 second", 32'h104, mem_word(32'h104), 1'b0);

        // Back-to-back redirects, first coinciding with a response
        do_reset(2);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("rd2 no req", {31'd0, imem_bus.req_valid}, 32'd0);
        tick();
        redirect_pc = 32'h300;
        #1;
        chk("rd2 flushed", {31'd0, instr_valid}, 32'd0);
        chk("rd2b no req", {31'd0, imem_bus.req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd3 flushed", {31'd0, instr_valid}, 32'd0);
        chk("rd3 req_valid", {31'd0, imem_bus.req_valid}, 32'd1);
        chk("rd3 req_addr", imem_bus.req_addr, 32'h300);
        wait_pop("rd3 first", 32'h300, mem_word(32'h300), 1'b0);
        wait_pop("rd3 second", 32'h304, mem_word(32'h304), 1'b0);

        // Misaligned redirect
        do_reset(1);
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        #1;
        tick();
        redirect = 1'b0;
        #1;
`ifdef IFU_ALIGN_CHECK_EN
        chk("align halt req", {31'd0, imem_bus.req_valid}, 32'd0);
        wait_pop("align fault", 32'h102, 32'h0000_0013, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("align halted req", {31'd0, imem_bus.req_valid}, 32'd0);
            chk("align halted valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        #1;
        wait_pop("align resume", 32'h400, mem_word(32'h400), 1'b0);
`else
        chk("align req_valid", {31'd0, imem_bus.req_valid}, 32'd1);
        chk("align req_addr", imem_bus.req_addr, 32'h100);
        wait_pop("align masked", 32'h100, mem_word(32'h100), 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
